// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: collects two 2-digit operands and an operator,
// drives an iterative add/sub/mul/div unit, then double-dabbles the result to BCD.
module calc_sequencer #(
  parameter logic [3:0] BLANK_CODE = 4'hF,
  parameter logic [3:0] ERR_CODE   = 4'hE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        KEY_VALID,
  input  logic [3:0]  KEY_CODE,
  output logic        KEY_READY,
  output logic [15:0] DISP,
  output logic [2:0]  OP_CODE,
  output logic        BUSY,
  output logic        RESULT_VALID,
  output logic        NEG,
  output logic        ERR
);

  typedef enum logic [2:0] {ENTER_A, ENTER_B, EXEC, CONV, DONE} state_t;

  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_MUL = 3'd3;
  localparam logic [2:0] OP_DIV = 3'd4;

  state_t      state_q;
  logic [6:0]  opA_q, opB_q, mq_q;
  logic [1:0]  count_q;
  logic [13:0] acc_q, aux_q;
  logic [3:0]  step_q;
  logic [15:0] bcd_q;

  logic        keyFire, isDigit, isOper;
  logic [2:0]  keyOp;
  logic [6:0]  entry_d;
  logic [1:0]  count_d;
  logic [13:0] mulAcc_d;
  logic [7:0]  remShift_d, remNext_d;
  logic        remGe_d;
  logic [6:0]  quot_d;
  logic [15:0] bcdAdj_d, bcdNext_d;

  function automatic logic [15:0] showOperand(input logic [6:0] v);
    logic [3:0] tens, ones;
    tens = 4'(v / 7'd10);
    ones = 4'(v % 7'd10);
    return {BLANK_CODE, BLANK_CODE, (tens == 4'd0) ? BLANK_CODE : tens, ones};
  endfunction

  // Leading zero nibbles are blanked; the ones digit is always shown.
  function automatic logic [15:0] showResult(input logic [15:0] b);
    logic [15:0] r;
    logic        lead;
    r    = b;
    lead = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      if (lead && b[4*i +: 4] == 4'd0) r[4*i +: 4] = BLANK_CODE;
      else lead = 1'b0;
    end
    return r;
  endfunction

  always_comb begin
    keyFire = KEY_VALID && KEY_READY;
    isDigit = KEY_CODE <= 4'd9;
    isOper  = (KEY_CODE >= 4'hA) && (KEY_CODE <= 4'hD);
    keyOp   = 3'(KEY_CODE - 4'd9);
    entry_d = {3'b000, KEY_CODE};
    count_d = 2'd1;
    if (count_q == 2'd1 && state_q != DONE) begin
      entry_d = 7'((state_q == ENTER_A ? opA_q : opB_q) * 7'd10) + {3'b000, KEY_CODE};
      count_d = 2'd2;
    end
    mulAcc_d   = mq_q[0] ? acc_q + aux_q : acc_q;
    remShift_d = {aux_q[6:0], mq_q[6]};
    remGe_d    = remShift_d >= {1'b0, opB_q};
    remNext_d  = remGe_d ? remShift_d - {1'b0, opB_q} : remShift_d;
    quot_d     = {mq_q[5:0], remGe_d};
    bcdAdj_d   = bcd_q;
    for (int i = 0; i < 4; i++) begin
      bcdAdj_d[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
    bcdNext_d = {bcdAdj_d[14:0], acc_q[13]};
  end

  // Clear key shares the reset path; it can only fire while the sequencer is idle.
  always_ff @(posedge CLK) begin
    if (RST || (keyFire && KEY_CODE == 4'hE)) begin
      state_q      <= ENTER_A;
      opA_q        <= '0;
      opB_q        <= '0;
      mq_q         <= '0;
      count_q      <= '0;
      acc_q        <= '0;
      aux_q        <= '0;
      step_q       <= '0;
      bcd_q        <= '0;
      OP_CODE      <= '0;
      DISP         <= {BLANK_CODE, BLANK_CODE, BLANK_CODE, 4'd0};
      BUSY         <= 1'b0;
      RESULT_VALID <= 1'b0;
      NEG          <= 1'b0;
      ERR          <= 1'b0;
      KEY_READY    <= 1'b1;
    end else begin
      RESULT_VALID <= 1'b0;
      case (state_q)
        ENTER_A, ENTER_B: begin
          if (keyFire) begin
            if (isDigit) begin
              if (state_q == ENTER_A) opA_q <= entry_d;
              else opB_q <= entry_d;
              count_q <= count_d;
              DISP    <= showOperand(entry_d);
            end else if (isOper) begin
              if (state_q == ENTER_A) begin
                OP_CODE <= keyOp;
                state_q <= ENTER_B;
                count_q <= '0;
                opB_q   <= '0;
              end else if (count_q == 2'd0) begin
                OP_CODE <= keyOp;
              end
            end else begin
              BUSY      <= 1'b1;
              KEY_READY <= 1'b0;
              step_q    <= '0;
              bcd_q     <= '0;
              if (state_q == ENTER_A) begin
                acc_q   <= {7'b0, opA_q};
                state_q <= CONV;
              end else begin
                state_q <= EXEC;
                acc_q   <= '0;
                // Divide reuses mq as dividend/quotient and aux as the remainder.
                if (OP_CODE == OP_DIV) begin
                  aux_q <= '0;
                  mq_q  <= opA_q;
                end else begin
                  aux_q <= {7'b0, opA_q};
                  mq_q  <= opB_q;
                end
              end
            end
          end
        end
        EXEC: begin
          case (OP_CODE)
            OP_MUL: begin
              acc_q  <= mulAcc_d;
              aux_q  <= aux_q << 1;
              mq_q   <= mq_q >> 1;
              step_q <= step_q + 4'd1;
              if (step_q == 4'd6) begin
                state_q <= CONV;
                step_q  <= '0;
              end
            end
            OP_DIV: begin
              if (opB_q == 7'd0) begin
                ERR          <= 1'b1;
                DISP         <= {BLANK_CODE, BLANK_CODE, ERR_CODE, ERR_CODE};
                state_q      <= DONE;
                RESULT_VALID <= 1'b1;
                BUSY         <= 1'b0;
                KEY_READY    <= 1'b1;
              end else begin
                aux_q  <= {6'b0, remNext_d};
                mq_q   <= quot_d;
                step_q <= step_q + 4'd1;
                if (step_q == 4'd6) begin
                  acc_q   <= {7'b0, quot_d};
                  state_q <= CONV;
                  step_q  <= '0;
                end
              end
            end
            OP_SUB: begin
              if (opA_q < opB_q) begin
                acc_q <= {7'b0, opB_q - opA_q};
                NEG   <= 1'b1;
              end else begin
                acc_q <= {7'b0, opA_q - opB_q};
              end
              state_q <= CONV;
            end
            default: begin
              acc_q   <= 14'(opA_q) + 14'(opB_q);
              state_q <= CONV;
            end
          endcase
        end
        CONV: begin
          acc_q  <= acc_q << 1;
          bcd_q  <= bcdNext_d;
          step_q <= step_q + 4'd1;
          if (step_q == 4'd13) begin
            DISP         <= showResult(bcdNext_d);
            state_q      <= DONE;
            RESULT_VALID <= 1'b1;
            BUSY         <= 1'b0;
            KEY_READY    <= 1'b1;
          end
        end
        DONE: begin
          if (keyFire && isDigit) begin
            opA_q   <= {3'b000, KEY_CODE};
            opB_q   <= '0;
            count_q <= 2'd1;
            OP_CODE <= '0;
            NEG     <= 1'b0;
            ERR     <= 1'b0;
            state_q <= ENTER_A;
            DISP    <= showOperand({3'b000, KEY_CODE});
          end
        end
        default: state_q <= ENTER_A;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: a key-level calculator model predicts each
// result, its latency and entry displays; a monitor checks every RESULT_VALID pulse.
module tb_calc_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        KEY_VALID = 1'b0;
  logic [3:0]  KEY_CODE = 4'd0;
  logic        KEY_READY;
  logic [15:0] DISP;
  logic [2:0]  OP_CODE;
  logic        BUSY, RESULT_VALID, NEG, ERR;

  calc_sequencer dut (
    .CLK(CLK), .RST(RST), .KEY_VALID(KEY_VALID), .KEY_CODE(KEY_CODE),
    .KEY_READY(KEY_READY), .DISP(DISP), .OP_CODE(OP_CODE), .BUSY(BUSY),
    .RESULT_VALID(RESULT_VALID), .NEG(NEG), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int edgeCount = 0;
  always @(posedge CLK) edgeCount <= edgeCount + 1;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [15:0] disp;
    logic        neg;
    logic        err;
    logic [2:0]  op;
    int          doneEdge;
  } exp_t;
  exp_t expQ[$];
  exp_t monExp;

  // Calculator model state: mode 0 = first operand, 1 = second operand, 2 = showing result
  int mMode, mA, mB, mCnt, mOp, mDoneEdge, mOperand;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, actual, expected, edgeCount);
  endtask

  function automatic logic [15:0] opDisp(input int v);
    int tens, ones;
    tens = v / 10;
    ones = v % 10;
    return {4'hF, 4'hF, (tens == 0) ? 4'hF : 4'(tens), 4'(ones)};
  endfunction

  function automatic logic [15:0] resDisp(input int v);
    int d[4];
    logic [15:0] r;
    bit started;
    d[0] = v % 10; d[1] = (v / 10) % 10; d[2] = (v / 100) % 10; d[3] = v / 1000;
    started = 1'b0;
    r = '0;
    for (int i = 3; i >= 1; i--) begin
      if (d[i] != 0) started = 1'b1;
      r[4*i +: 4] = started ? 4'(d[i]) : 4'hF;
    end
    r[3:0] = 4'(d[0]);
    return r;
  endfunction

  task automatic modelReset();
    mMode = 0; mA = 0; mB = 0; mCnt = 0; mOp = 0; mDoneEdge = 0; mOperand = 0;
  endtask

  task automatic pushResult(input logic [15:0] disp, input logic neg, input logic err, input int doneEdge);
    exp_t e;
    e.disp = disp; e.neg = neg; e.err = err; e.op = 3'(mOp); e.doneEdge = doneEdge;
    expQ.push_back(e);
    mDoneEdge = doneEdge;
    mMode = 2;
  endtask

  task automatic modelKey(input int k, input int acceptEdge);
    int cur, r;
    if (k == 14) begin
      modelReset();
    end else if (k <= 9) begin
      if (mMode == 2) begin
        mA = k; mB = 0; mCnt = 1; mOp = 0; mMode = 0; cur = k;
      end else begin
        cur = (mMode == 0) ? mA : mB;
        if (mCnt == 1) begin cur = cur * 10 + k; mCnt = 2; end
        else begin cur = k; mCnt = 1; end
        if (mMode == 0) mA = cur; else mB = cur;
      end
      mOperand = cur;
    end else if (k <= 13) begin
      if (mMode == 0) begin
        mOp = k - 9; mMode = 1; mCnt = 0; mB = 0;
      end else if (mMode == 1 && mCnt == 0) begin
        mOp = k - 9;
      end
    end else begin
      if (mMode == 0) begin
        pushResult(resDisp(mA), 1'b0, 1'b0, acceptEdge + 14);
      end else if (mMode == 1) begin
        case (mOp)
          1: pushResult(resDisp(mA + mB), 1'b0, 1'b0, acceptEdge + 15);
          2: begin
            r = (mA < mB) ? mB - mA : mA - mB;
            pushResult(resDisp(r), mA < mB, 1'b0, acceptEdge + 15);
          end
          3: pushResult(resDisp(mA * mB), 1'b0, 1'b0, acceptEdge + 21);
          default: begin
            if (mB == 0) pushResult(16'hFFEE, 1'b0, 1'b1, acceptEdge + 1);
            else pushResult(resDisp(mA / mB), 1'b0, 1'b0, acceptEdge + 21);
          end
        endcase
      end
    end
  endtask

  // Offer one key, hold it until accepted, and check when acceptance happened.
  task automatic applyStimulus(input logic [3:0] k);
    int startEdge, acceptEdge, waited;
    @(negedge CLK);
    startEdge = edgeCount;
    KEY_CODE = k;
    KEY_VALID = 1'b1;
    waited = 0;
    while (KEY_READY !== 1'b1 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    if (KEY_READY !== 1'b1) begin
      checkCount++;
      $display("[TB] FAIL keyTimeout: key %0h not accepted within 100 cycles, KEY_READY=%b", k, KEY_READY);
      KEY_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    #1;
    acceptEdge = edgeCount;
    KEY_VALID = 1'b0;
    checkOutput("acceptEdge", 32'(acceptEdge), 32'(((mDoneEdge > startEdge) ? mDoneEdge : startEdge) + 1));
    modelKey(int'(k), acceptEdge);
    if (k <= 4'd9) begin
      @(negedge CLK);
      checkOutput("entryDisp", 32'(DISP), 32'(opDisp(mOperand)));
      checkOutput("entryFlags", 32'({OP_CODE, NEG, ERR, BUSY}), 32'({3'(mOp), 3'b000}));
    end
  endtask

  task automatic checkResetState();
    checkOutput("rstReady", 32'(KEY_READY), 32'd1);
    checkOutput("rstDisp", 32'(DISP), 32'hFFF0);
    checkOutput("rstOp", 32'(OP_CODE), 32'd0);
    checkOutput("rstFlags", 32'({BUSY, RESULT_VALID, NEG, ERR}), 32'd0);
  endtask

  // Monitor: every result pulse must match the oldest outstanding prediction.
  always @(negedge CLK) begin
    if (!RST && RESULT_VALID === 1'b1) begin
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpectedResult: RESULT_VALID=1 at edge %0d, expected no pulse", edgeCount);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("resultEdge", 32'(edgeCount), 32'(monExp.doneEdge));
        checkOutput("resultDisp", 32'(DISP), 32'(monExp.disp));
        checkOutput("resultNeg", 32'(NEG), 32'(monExp.neg));
        checkOutput("resultErr", 32'(ERR), 32'(monExp.err));
        checkOutput("resultOp", 32'(OP_CODE), 32'(monExp.op));
        checkOutput("resultBusy", 32'({BUSY, KEY_READY}), 32'b01);
      end
    end
  end

  logic [3:0] seqMain[$] = '{4'h1, 4'h2, 4'hC, 4'h3, 4'h4, 4'hF};
  logic [3:0] seqMore[$] = '{4'h4, 4'h2, 4'hA, 4'h7, 4'hF, 4'h5, 4'hB, 4'h9, 4'hF,
                            4'h9, 4'h9, 4'hD, 4'h0, 4'hF, 4'h3, 4'hE,
                            4'h9, 4'h9, 4'hC, 4'h9, 4'h9, 4'hF, 4'h1, 4'h2, 4'h3, 4'hF,
                            4'hE, 4'h6, 4'hA, 4'hB, 4'h2, 4'hF, 4'hE,
                            4'h9, 4'h9, 4'hD, 4'h7, 4'hF};
  logic [3:0] seqAbort[$] = '{4'h8, 4'hC, 4'h7, 4'hF};

  initial begin
    int r, waited;
    logic [3:0] k;
    modelReset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    checkResetState();

    foreach (seqMain[i]) applyStimulus(seqMain[i]);
    @(negedge CLK);
    checkOutput("busyDuringExec", 32'({BUSY, KEY_READY}), 32'b10);
    foreach (seqMore[i]) applyStimulus(seqMore[i]);

    applyStimulus(4'hE);
    foreach (seqAbort[i]) applyStimulus(seqAbort[i]);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    expQ.delete();
    modelReset();
    @(negedge CLK);
    checkResetState();
    repeat (30) @(negedge CLK);

    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55) k = 4'($urandom_range(0, 9));
      else if (r < 75) k = 4'($urandom_range(10, 13));
      else if (r < 93) k = 4'hF;
      else k = 4'hE;
      applyStimulus(k);
    end

    waited = 0;
    while (expQ.size() != 0 && waited < 100) begin
      @(negedge CLK);
      waited++;
    end
    checkOutput("pendingResults", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
